// File: rtl/wbtimeout.sv
// wbtimeout: Wishbone bus watchdog between the arbiter's shared master port
// and the slave interconnect. All pass-through paths are combinational. The
// block tracks outstanding pipelined requests, aborts any cycle that makes no
// progress for TIMEOUT clocks with a one-cycle bus error to the master, and
// records the faulting address for software.
//
// Ports:
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   i_cyc/i_stb/i_we/i_adr/i_dat    master request (from arbiter)
//   o_ack/o_stall/o_err/o_data      master response
//   o_cyc/o_stb/o_we/o_adr/o_dat    slave request
//   i_ack/i_stall/i_err/i_data      slave response
//   o_fault, o_fault_adr            sticky fault flag and captured address
//   i_fault_clr                     clears o_fault (address is retained)
module wbtimeout #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 19,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TW      = 10,
    parameter int unsigned LGNOUT  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // master side
    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [AW-1:0] i_adr,
    input  logic [DW-1:0] i_dat,
    output logic          o_ack,
    output logic          o_stall,
    output logic          o_err,
    output logic [DW-1:0] o_data,
    // slave side
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_adr,
    output logic [DW-1:0] o_dat,
    input  logic          i_ack,
    input  logic          i_stall,
    input  logic          i_err,
    input  logic [DW-1:0] i_data,
    // fault reporting
    output logic          o_fault,
    output logic [AW-1:0] o_fault_adr,
    input  logic          i_fault_clr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] ABORT  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [LGNOUT-1:0] nout_q,      nout_d;
    logic [TW-1:0]     timer_q,     timer_d;
    logic              err_q,       err_d;
    logic              fault_q,     fault_d;
    logic [AW-1:0]     fault_adr_q, fault_adr_d;
    logic [AW-1:0]     last_adr_q,  last_adr_d;

    logic in_abort;
    logic sat;
    logic has_nout;
    logic accept;
    logic ack_dec;
    logic counting;
    logic timeout;
    logic fault_event;

    // Pass-through paths and the abort override
    always_comb begin
        in_abort = (state_q == ABORT);
        sat      = &nout_q;
        has_nout = (nout_q != '0);

        o_cyc    = i_cyc && !in_abort;
        o_stb    = i_cyc && i_stb && !sat && !in_abort;
        o_we     = i_we;
        o_adr    = i_adr;
        o_dat    = i_dat;
        o_data   = i_data;
        o_stall  = in_abort || sat || i_stall;
        o_ack    = i_ack && has_nout && !in_abort;
        o_err    = err_q || ((state_q == ACTIVE) && i_err);

        accept   = o_stb && !i_stall;
        ack_dec  = i_ack && has_nout;
    end

    // Progress watchdog: a cycle counts only while something is owed to the
    // master and neither an ack nor a newly accepted request shows progress.
    always_comb begin
        counting = (state_q == ACTIVE) && i_cyc
                && (has_nout || (i_stb && i_stall))
                && !i_ack && !accept;
        timeout  = counting && (timer_q == TW'(TIMEOUT - 1));
        fault_event = (state_q == ACTIVE) && (timeout || i_err);
    end

    // Next-state, counters and fault capture
    always_comb begin
        state_d     = state_q;
        nout_d      = nout_q;
        timer_d     = '0;
        err_d       = 1'b0;
        fault_d     = fault_q;
        fault_adr_d = fault_adr_q;
        last_adr_d  = last_adr_q;

        if (accept) begin
            last_adr_d = i_adr;
        end

        case (state_q)
            IDLE: begin
                // A cycle may open and issue its first request in the same clock.
                nout_d = LGNOUT'(accept);
                if (i_cyc) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fault_event) begin
                    state_d = ABORT;
                    nout_d  = '0;
                    err_d   = timeout;
                end else if (!i_cyc) begin
                    state_d = IDLE;
                    nout_d  = '0;
                end else begin
                    if (accept && !ack_dec) begin
                        nout_d = nout_q + LGNOUT'(1);
                    end else if (ack_dec && !accept) begin
                        nout_d = nout_q - LGNOUT'(1);
                    end
                    if (counting) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ABORT: begin
                nout_d = '0;
                if (!i_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                nout_d  = '0;
            end
        endcase

        // A new fault wins over a simultaneous clear.
        if (fault_event) begin
            fault_d     = 1'b1;
            fault_adr_d = (i_stb && i_stall) ? i_adr : last_adr_q;
        end else if (i_fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            nout_q      <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
            fault_adr_q <= '0;
            last_adr_q  <= '0;
        end else begin
            state_q     <= state_d;
            nout_q      <= nout_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
            last_adr_q  <= last_adr_d;
        end
    end

    assign o_fault     = fault_q;
    assign o_fault_adr = fault_adr_q;

endmodule

// File: doc/wbtimeout.md
# wbtimeout

Wishbone bus watchdog placed directly downstream of the two-master arbiter. It sits between the arbiter's shared master port and the slave interconnect.
- Passes every transaction through with zero added latency.
- Tracks outstanding pipelined requests.
- Aborts any cycle that makes no progress for TIMEOUT clocks, returning a one-cycle bus error to the owning master.
- Records the faulting address for software.

## Interface
- DW, 32: data width
- AW, 19: address width
- TIMEOUT, 1000: clocks without progress before abort; must be ≥2
- TW, 10: timer width; 2^TW > TIMEOUT required
- LGNOUT, 4: outstanding-request counter width

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_cyc, i_stb, i_we  in  1 each  master side (from arbiter)
- i_adr  in  AW  master address
- i_dat  in  DW  master write data
- o_ack, o_stall, o_err  out  1 each  to master
- o_data  out  DW  read data to master (direct copy of i_data)
- o_cyc, o_stb, o_we  out  1 each  slave side
- o_adr  out  AW  slave address
- o_dat  out  DW  slave write data
- i_ack, i_stall, i_err  in  1 each  from slave
- i_data  in  DW  slave read data
- o_fault  out  1  sticky fault flag
- o_fault_adr  out  AW  captured fault address
- i_fault_clr  in  1  clears o_fault

## Operation
- States: IDLE, ACTIVE, ABORT.
  - IDLE→ACTIVE when i_cyc=1.
  - ACTIVE→IDLE when i_cyc=0.
  - ACTIVE→ABORT on timeout or i_err.
  - ABORT→IDLE when i_cyc=0.
- Pass-through (state≠ABORT): o_cyc=i_cyc, so cycles start the same clock even from IDLE.
  - o_stb=i_cyc&&i_stb&&!sat.
  - o_adr/o_dat/o_we follow the master unconditionally.
- In ABORT: o_cyc=o_stb=0, o_stall=1, o_ack=0. ABORT holds until the master drops i_cyc.
- Outstanding count nout (LGNOUT bits):
  - +1 on accepted request (o_stb&&!i_stall); −1 on i_ack while nout≠0.
  - Both in the same cycle: unchanged.
  - Cleared in IDLE and on entry to ABORT.
- sat = (nout all-ones). While sat, o_stall=1 and o_stb=0 regardless of i_stall. Otherwise o_stall=i_stall.
- o_ack = i_ack && nout≠0 && state≠ABORT. Stray acks are dropped.
- Timer:
  - Counts when ACTIVE, with nout≠0 or (i_stb && i_stall), and no i_ack and no accepted request this cycle.
  - Resets to 0 on any non-counting cycle.
- Timeout fires when counting with timer==TIMEOUT−1. It sets r_err for one cycle and enters ABORT.
- o_err = r_err || (state==ACTIVE && i_err). A slave i_err is forwarded combinationally the same cycle and enters ABORT next clock.
- Address tracking: r_last_adr is loaded with i_adr on every accepted request.
- Fault capture on timeout or i_err:
  - o_fault <= 1.
  - o_fault_adr <= i_adr if a stalled strobe is pending (i_stb&&i_stall), else r_last_adr.
  - New fault beats a simultaneous i_fault_clr.
- i_fault_clr alone clears o_fault; o_fault_adr is retained.
- Reset (i_rst_n=0 at clock edge): state=IDLE, nout=0, timer=0, r_err=0, o_fault=0, o_fault_adr=0, r_last_adr=0.
- Reset mid-cycle drops everything; no error pulse.
- Combinational outputs after reset: o_cyc follows i_cyc, o_ack/o_err=0.

## Timing
- Zero-cycle latency on all pass-through paths (cyc, stb, adr, dat, we, ack, stall, data).
- Timeout latency:
  - Request accepted at cycle 0 and never acked: timer=k−1 on counting cycle k.
  - o_err is high for exactly cycle TIMEOUT+1.
  - o_cyc is low from cycle TIMEOUT+1 on.
- Each ack or accepted request restarts the full TIMEOUT window.
- o_cyc is guaranteed low for ≥1 cycle after abort, because ABORT persists at least until i_cyc drops.
- o_fault rises the cycle after the fault event (registered).

## Test plan
- Single read (TIMEOUT=8): stb accepted cycle 0, i_ack at cycle 3 with i_data=0xDEADBEEF → o_ack/o_data pass through at cycle 3; o_err never asserted; nout returns to 0.
- Timeout (TIMEOUT=8): stb at cycle 0, adr=0x1234, no ack → o_err=1 only at cycle 9; o_cyc=0 from cycle 9; o_fault=1 and o_fault_adr=0x1234 at cycle 10; a late i_ack at cycle 11 gives o_ack=0.
- Stalled strobe (TIMEOUT=8): i_stb held with i_stall=1 and nothing outstanding → abort after 8 counting cycles; o_fault_adr = stalled i_adr.
- Pipelined burst (LGNOUT=2): 5 back-to-back strobes with no acks → first 3 accepted, then o_stall=1 and o_stb=0; acks release the pipeline; with ack and stb in the same cycle, nout stays constant.
- Slave error: i_err at cycle 2 → o_err=1 the same cycle; ABORT from cycle 3; o_fault set; i_fault_clr together with a new timeout leaves o_fault=1.
- Reset: i_rst_n=0 mid-burst with nout=2 → next cycle nout=0, o_fault=0, no o_err; new cycle proceeds normally.
